alu_reg: RTL and testbench

- Registered 32-bit integer ALU for the RISC-V execute stage.
- Computes arithmetic, logic, compare and shift results from operands A and B, selected by a 4-bit op code S.
- Result F and zero flag appear one clock after a valid request.
- zeroflag drives branch-equality decisions.

---
 rtl/alu_reg.sv | 88 ++++++++
 tb/tb_alu_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_reg.sv
// Registered integer ALU for the execute stage.
// Ports: clk, rst (async, active-high), in_valid/A/B/S request, out_valid/F/zeroflag result.
module alu_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  output logic             out_valid,
  output logic [WIDTH-1:0] F,
  output logic             zeroflag
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [WIDTH-1:0] res;
  logic [SHW-1:0]   shamt;
  logic             lt_s;
  logic             lt_u;

  logic [WIDTH-1:0] f_d, f_q;
  logic             z_d, z_q;
  logic             v_d, v_q;

  assign shamt = B[SHW-1:0];
  assign lt_s  = $signed(A) < $signed(B);
  assign lt_u  = A < B;

  always_comb begin
    res = '0;
    unique case (S)
      OP_ADD:  res = A + B;
      OP_SUB:  res = A - B;
      OP_XOR:  res = A ^ B;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLL:  res = A << shamt;
      OP_SRL:  res = A >> shamt;
      OP_OR:   res = A | B;
      OP_AND:  res = A & B;
      OP_SRA:  res = $unsigned($signed(A) >>> shamt);
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
      default: res = '0;
    endcase
  end

  // zero flag follows the value being written, not the old F
  always_comb begin
    f_d = f_q;
    z_d = z_q;
    v_d = 1'b0;
    if (in_valid) begin
      f_d = res;
      z_d = (res == '0);
      v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q <= '0;
      z_q <= 1'b1;
      v_q <= 1'b0;
    end else begin
      f_q <= f_d;
      z_q <= z_d;
      v_q <= v_d;
    end
  end

  assign F         = f_q;
  assign zeroflag  = z_q;
  assign out_valid = v_q;

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg.
// Reference model plus directed literal checks and random traffic.
module tb_alu_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  S = '0;
  logic        out_valid;
  logic [31:0] F;
  logic        zeroflag;

  int checks = 0;
  int errors = 0;

  alu_reg #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .S(S),
    .out_valid(out_valid),
    .F(F),
    .zeroflag(zeroflag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  s
  );
    int sh;
    longint sa, sb;
    logic [31:0] r;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s)
      4'd0: r = 32'(64'(a) + 64'(b));
      4'd1: r = 32'(64'(a) + 64'(~b) + 64'd1);
      4'd2: r = a ^ b;
      4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: r = 32'(64'(a) * (64'd1 << sh));
      4'd5: r = 32'(64'(a) / (64'd1 << sh));
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd8: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      4'd9: r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] exp_f = 32'd0;
  logic        exp_z = 1'b1;
  logic        exp_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_f <= 32'd0;
      exp_z <= 1'b1;
      exp_v <= 1'b0;
    end else if (in_valid) begin
      exp_f <= ref_alu(A, B, S);
      exp_z <= (ref_alu(A, B, S) == 32'd0);
      exp_v <= 1'b1;
    end else begin
      exp_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (out_valid !== exp_v || F !== exp_f || zeroflag !== exp_z) begin
      errors++;
      $display("FAIL model t=%0t got v=%b F=%h z=%b want v=%b F=%h z=%b",
               $time, out_valid, F, zeroflag, exp_v, exp_f, exp_z);
    end
  end

  task automatic lit(input string nm, input logic [31:0] ef,
                     input logic ez, input logic ev);
    checks++;
    if (F !== ef || zeroflag !== ez || out_valid !== ev) begin
      errors++;
      $display("FAIL %s got v=%b F=%h z=%b want v=%b F=%h z=%b",
               nm, out_valid, F, zeroflag, ev, ef, ez);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] s, input string nm,
                      input logic [31:0] ef, input logic ez);
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    S = s;
    @(posedge clk);
    #1;
    lit(nm, ef, ez, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    S = 4'($urandom);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] TA = 32'h1234_5678;
  localparam logic [31:0] TB = 32'h99AD_BEF0;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 lit("reset_state", 32'd0, 1'b1, 1'b0);

    send(TA, TB, 4'b0000, "add", 32'hABE2_1568, 1'b0);
    send(TA, TB, 4'b0001, "sub", 32'h7886_9788, 1'b0);
    send(TA, TB, 4'b0010, "xor", 32'h8B99_E888, 1'b0);
    send(TA, TB, 4'b0110, "or",  32'h9BBD_FEF8, 1'b0);
    send(TA, TB, 4'b0111, "and", 32'h1024_1670, 1'b0);
    send(TA, TB, 4'b0011, "slt", 32'd0, 1'b1);
    send(TA, TB, 4'b1001, "sltu", 32'd1, 1'b0);
    send(TA, 32'd4, 4'b0100, "sll4", 32'h2345_6780, 1'b0);
    send(TA, 32'd4, 4'b0101, "srl4", 32'h0123_4567, 1'b0);
    send(TB, 32'h24, 4'b1000, "sra_0x24", 32'hF99A_DBEF, 1'b0);
    send(TA, 32'd0, 4'b0100, "sll0", TA, 1'b0);
    send(TB, 32'd31, 4'b1000, "sra31", 32'hFFFF_FFFF, 1'b0);
    send(TA, 32'hFFFF_FFFF, 4'b0101, "srl31", 32'd0, 1'b1);
    send(TA, TB, 4'b1010, "undef", 32'd0, 1'b1);
    send(TA, TB, 4'b1111, "undef_f", 32'd0, 1'b1);
    send(TA, TB, 4'b0000, "add_again", 32'hABE2_1568, 1'b0);

    repeat (3) idle();
    @(posedge clk);
    #1 lit("hold3", 32'hABE2_1568, 1'b0, 1'b0);

    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0001, "sub_zero", 32'd0, 1'b1);
    send(32'hFFFF_FFFF, 32'd1, 4'b0000, "add_wrap", 32'd0, 1'b1);

    // reset in the middle of a valid stream, checked before any edge
    send(TA, TB, 4'b0010, "pre_rst", 32'h8B99_E888, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 lit("async_rst", 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1 lit("rst_held", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      A = pick();
      B = pick();
      S = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
